wb_reg_file: RTL and testbench

//  Write-back end of the MEM/WB pipeline boundary. Consumes the WB_* signals from the MEM/WB register,

---
 rtl/wb_reg_file.sv | 73 +++++++
 tb/tb_wb_reg_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// rtl/wb_reg_file.sv - MEM/WB write-back mux, 32-entry GPR file with read bypass and retire counter
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] WB_ReadData,
    input  logic [DATA_W-1:0] WB_ALUresult,
    input  logic [ADDR_W-1:0] WB_WriteReg,
    input  logic              WB_RegWrite,
    input  logic              WB_MemtoReg,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WB_WriteData_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] wb_data;
    logic              wr_en;

    assign wb_data        = WB_MemtoReg ? WB_ReadData : WB_ALUresult;
    assign WB_WriteData_o = wb_data;
    assign retire_cnt_o   = cnt_q;

    // Gating with rst_i also disables the bypass while reset is held.
    assign wr_en = rst_i && WB_RegWrite && (WB_WriteReg != '0);
    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wr_en) begin
            regs_q[WB_WriteReg] <= wb_data;
            cnt_q               <= cnt_d;
        end
    end

    always_comb begin
        RSdata_o = '0;
        if (rst_i && (RSaddr_i != '0)) begin
            if (BYPASS && wr_en && (WB_WriteReg == RSaddr_i)) begin
                RSdata_o = wb_data;
            end else begin
                RSdata_o = regs_q[RSaddr_i];
            end
        end
    end

    always_comb begin
        RTdata_o = '0;
        if (rst_i && (RTaddr_i != '0)) begin
            if (BYPASS && wr_en && (WB_WriteReg == RTaddr_i)) begin
                RTdata_o = wb_data;
            end else begin
                RTdata_o = regs_q[RTaddr_i];
            end
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// tb/tb_wb_reg_file.sv - three configurations (bypass, no bypass, 4-bit counter) driven in lockstep against a reference model
`timescale 1ns/1ps
module tb_wb_reg_file;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] WB_ReadData, WB_ALUresult;
    logic [4:0]  WB_WriteReg, RSaddr_i, RTaddr_i;
    logic        WB_RegWrite, WB_MemtoReg;

    logic [31:0] a_rs, a_rt, a_wb, a_cnt;
    logic [31:0] b_rs, b_rt, b_wb, b_cnt;
    logic [31:0] c_rs, c_rt, c_wb;
    logic [3:0]  c_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_cnt;

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .CNT_W(32)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .WB_ReadData(WB_ReadData), .WB_ALUresult(WB_ALUresult),
        .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(a_rs), .RTdata_o(a_rt),
        .WB_WriteData_o(a_wb), .retire_cnt_o(a_cnt));

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .CNT_W(32)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .WB_ReadData(WB_ReadData), .WB_ALUresult(WB_ALUresult),
        .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(b_rs), .RTdata_o(b_rt),
        .WB_WriteData_o(b_wb), .retire_cnt_o(b_cnt));

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .CNT_W(4)) u_c (
        .clk_i(clk_i), .rst_i(rst_i), .WB_ReadData(WB_ReadData), .WB_ALUresult(WB_ALUresult),
        .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(c_rs), .RTdata_o(c_rt),
        .WB_WriteData_o(c_wb), .retire_cnt_o(c_cnt));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return WB_MemtoReg ? WB_ReadData : WB_ALUresult;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (rst_i !== 1'b1 || addr == 5'd0) return 32'h0;
        if (byp && WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == addr) return exp_wb();
        return m_reg[addr];
    endfunction

    // Reference state: a plain array plus a wide counter; narrow counters compare modulo 16.
    always @(negedge rst_i) begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_cnt = 32'h0;
    end

    always @(posedge clk_i) begin
        if (rst_i === 1'b1 && WB_RegWrite && WB_WriteReg != 5'd0) begin
            m_reg[WB_WriteReg] = exp_wb();
            m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_i !== 1'bx) begin
            chk("a_rs", a_rs, exp_read(RSaddr_i, 1'b1));
            chk("a_rt", a_rt, exp_read(RTaddr_i, 1'b1));
            chk("b_rs", b_rs, exp_read(RSaddr_i, 1'b0));
            chk("b_rt", b_rt, exp_read(RTaddr_i, 1'b0));
            chk("c_rs", c_rs, exp_read(RSaddr_i, 1'b1));
            chk("c_rt", c_rt, exp_read(RTaddr_i, 1'b1));
            chk("a_wb", a_wb, exp_wb());
            chk("b_wb", b_wb, exp_wb());
            chk("c_wb", c_wb, exp_wb());
            chk("a_cnt", a_cnt, m_cnt);
            chk("b_cnt", b_cnt, m_cnt);
            chk("c_cnt", {28'h0, c_cnt}, {28'h0, m_cnt[3:0]});
        end
    end

    task automatic drive(input logic we, input logic mtr, input logic [4:0] wr,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk_i);
        #1;
        WB_RegWrite = we; WB_MemtoReg = mtr; WB_WriteReg = wr;
        WB_ReadData = rd; WB_ALUresult = alu; RSaddr_i = rs; RTaddr_i = rt;
    endtask

    task automatic reset_pulse();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_cnt = 32'h0;
        rst_i = 1'b0;
        WB_RegWrite = 1'b0; WB_MemtoReg = 1'b0; WB_WriteReg = 5'd0;
        WB_ReadData = 32'h0; WB_ALUresult = 32'h0; RSaddr_i = 5'd0; RTaddr_i = 5'd0;
        repeat (2) @(posedge clk_i);
        #2 chk("reset_cnt", a_cnt, 32'h0);
        #1 rst_i = 1'b1;

        // ALU then load write-back
        drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0000_00A5, 5'd5, 5'd5);
        drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd5, 5'd7);
        #2 chk("alu_reg5", a_rs, 32'h0000_00A5);
        chk("alu_cnt1", a_cnt, 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);
        #2 chk("load_reg7", a_rs, 32'hDEAD_BEEF);
        chk("load_cnt2", a_cnt, 32'd2);

        // Write to the zero register
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #2 chk("zero_rs", a_rs, 32'h0);
        chk("zero_rt", a_rt, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        #2 chk("zero_cnt", a_cnt, 32'd2);

        // Same-cycle bypass vs. old value
        drive(1'b1, 1'b0, 5'd9, 32'h0, 32'h1, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd9, 32'h0, 32'h2, 5'd9, 5'd9);
        #2 chk("byp1_rs", a_rs, 32'h2);
        chk("byp1_rt", a_rt, 32'h2);
        chk("byp0_rs", b_rs, 32'h1);
        chk("byp0_rt", b_rt, 32'h1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
        #2 chk("byp0_after_rs", b_rs, 32'h2);
        chk("byp0_after_rt", b_rt, 32'h2);

        // 4-bit counter wraps after 16 commits
        reset_pulse();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 5'd3, 32'h0, 32'd100 + 32'(i), 5'd3, 5'd0);
            if (i == 15) #2 chk("wrap_cnt15", {28'h0, c_cnt}, 32'd15);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
        #2 chk("wrap_cnt0", {28'h0, c_cnt}, 32'd0);
        chk("wrap_reg3", c_rs, 32'd115);

        // Reset asserted on the same edge as a pending write
        drive(1'b1, 1'b0, 5'd4, 32'h0, 32'h55, 5'd4, 5'd4);
        @(posedge clk_i);
        rst_i = 1'b0;
        #2 WB_RegWrite = 1'b0;
        #1 rst_i = 1'b1;
        #1 chk("rstedge_reg4", a_rs, 32'h0);
        chk("rstedge_cnt", a_cnt, 32'h0);

        // Randomised traffic with occasional reset cycles
        for (int n = 0; n < 600; n++) begin
            @(posedge clk_i);
            #1;
            rst_i        = ($urandom_range(0, 59) != 0);
            WB_RegWrite  = ($urandom_range(0, 3) != 0);
            WB_MemtoReg  = $urandom_range(0, 1) != 0;
            WB_WriteReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            WB_ReadData  = $urandom;
            WB_ALUresult = $urandom;
            RSaddr_i     = ($urandom_range(0, 2) == 0) ? WB_WriteReg : 5'($urandom_range(0, 31));
            RTaddr_i     = ($urandom_range(0, 2) == 0) ? WB_WriteReg : 5'($urandom_range(0, 31));
        end

        // Asynchronous reset clears every entry without an edge
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        WB_RegWrite = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'(i), 32'h0, 32'hA000_0000 + 32'(i), 5'd1, 5'd1);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd30);
        #2 chk("pre_rst_r31", a_rs, 32'hA000_001F);
        #1 rst_i = 1'b0;
        #1 chk("async_cnt", a_cnt, 32'h0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk_i);
            #1 RSaddr_i = 5'(i);
            RTaddr_i = 5'(31 - i);
            #2 chk("rst_sweep_rs", a_rs, 32'h0);
            chk("rst_sweep_rt", b_rt, 32'h0);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
